// File: rtl/lector_vga_if.sv
// lector_vga_if -- signal bundle between the VGA reader and its surroundings.
//   vgae      : video enable, into the reader
//   rd_addr   : framebuffer read address, out of the reader (15 bits)
//   rd_data   : framebuffer pixel {R,G,B}, into the reader (1-clock RAM latency)
//   VGA_R/G/B : 4-bit colour pins
//   VGA_HS/VS : active-low syncs
//   VGA_BLANK : 1 = visible pixel
//   VGA_SYNC  : composite sync, tied low
//   frame     : one-clock frame-start pulse
// The master modport is the reader itself; the slave modport is the
// framebuffer/monitor side.
interface lector_vga_if;
    logic        vgae;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK;
    logic        VGA_SYNC;
    logic        frame;

    modport master (
        input  vgae, rd_data,
        output rd_addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK, VGA_SYNC, frame
    );

    modport slave (
        output vgae, rd_data,
        input  rd_addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK, VGA_SYNC, frame
    );
endinterface

// File: rtl/lector_vga.sv
// lector_vga -- scans a 160x120x3-bit framebuffer out as a VGA raster, each
// framebuffer pixel covering a 4x4 block of screen pixels.
// Ports:
//   clk   : pixel clock, rising edge
//   reset : asynchronous, active-low
//   vga   : lector_vga_if.master (vgae, rd_addr/rd_data, VGA pins, frame)
// Pipeline: counters -> rd_addr register -> RAM data -> output registers, so
// the pins show counter position (h,v) three clocks after the counters hold it.
// Sync, active and enable flags ride a matching delay line (two stages plus
// the output register).
module lector_vga #(
    parameter int unsigned H_ACT = 640,
    parameter int unsigned H_FP  = 16,
    parameter int unsigned H_SYN = 96,
    parameter int unsigned H_BP  = 48,
    parameter int unsigned V_ACT = 480,
    parameter int unsigned V_FP  = 10,
    parameter int unsigned V_SYN = 2,
    parameter int unsigned V_BP  = 33
) (
    input  logic         clk,
    input  logic         reset,
    lector_vga_if.master vga
);

    localparam int unsigned H_TOT = H_ACT + H_FP + H_SYN + H_BP;
    localparam int unsigned V_TOT = V_ACT + V_FP + V_SYN + V_BP;

    localparam logic [9:0] H_ACT_C  = 10'(H_ACT);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACT);
    localparam logic [9:0] H_LAST_C = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST_C = 10'(V_TOT - 1);
    localparam logic [9:0] HS_BEG_C = 10'(H_ACT + H_FP);
    localparam logic [9:0] HS_END_C = 10'(H_ACT + H_FP + H_SYN);
    localparam logic [9:0] VS_BEG_C = 10'(V_ACT + V_FP);
    localparam logic [9:0] VS_END_C = 10'(V_ACT + V_FP + V_SYN);

    // Replicate one framebuffer colour bit onto a 4-bit DAC channel.
    function automatic logic [3:0] rep4(input logic bit_i);
        return {4{bit_i}};
    endfunction

    // Stage 1: raster counters. run_q is clear for the first edge after reset
    // so that edge loads (0,0) and raises frame, then counting proceeds.
    logic        run_q;
    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        frame_q, frame_d;

    // Stage 2: read address plus first delay-line stage.
    logic [14:0] rd_addr_q, rd_addr_d;
    logic        hs_a_q, hs_a_d;
    logic        vs_a_q, vs_a_d;
    logic        act_a_q, act_a_d;
    logic        en_a_q, en_a_d;

    // Stage 3: second delay-line stage, lined up with rd_data.
    logic        hs_b_q;
    logic        vs_b_q;
    logic        act_b_q;
    logic        en_b_q;

    // Stage 4: output registers.
    logic [3:0]  r_q, r_d;
    logic [3:0]  g_q, g_d;
    logic [3:0]  b_q, b_d;
    logic        hs_q;
    logic        vs_q;
    logic        blank_q;

    logic        active_s;
    logic        hs_s;
    logic        vs_s;
    logic [7:0]  fx_s;
    logic [7:0]  fy_s;
    logic [14:0] addr_s;

    // Next-state logic for counters, address and colour.
    always_comb begin
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        rd_addr_d = 15'd0;
        hs_a_d    = 1'b1;
        vs_a_d    = 1'b1;
        act_a_d   = 1'b0;
        en_a_d    = 1'b0;
        r_d       = 4'h0;
        g_d       = 4'h0;
        b_d       = 4'h0;

        if (!run_q) begin
            hcnt_d = 10'd0;
            vcnt_d = 10'd0;
        end else if (hcnt_q == H_LAST_C) begin
            hcnt_d = 10'd0;
            if (vcnt_q == V_LAST_C) begin
                vcnt_d = 10'd0;
            end else begin
                vcnt_d = vcnt_q + 10'd1;
            end
        end else begin
            hcnt_d = hcnt_q + 10'd1;
        end
        frame_d = (hcnt_d == 10'd0) && (vcnt_d == 10'd0);

        active_s = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
        hs_s     = !((hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C));
        vs_s     = !((vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C));

        // fy*160 + fx as (fy<<7) + (fy<<5) + fx; max 119*160+159 fits 15 bits.
        fx_s   = hcnt_q[9:2];
        fy_s   = vcnt_q[9:2];
        addr_s = {fy_s, 7'd0} + {2'd0, fy_s, 5'd0} + {7'd0, fx_s};

        // Before the first counting edge the counters are not a real
        // position yet, so the delay line keeps its idle values.
        if (run_q) begin
            rd_addr_d = active_s ? addr_s : 15'd0;
            hs_a_d    = hs_s;
            vs_a_d    = vs_s;
            act_a_d   = active_s;
            en_a_d    = vga.vgae;
        end else begin
            rd_addr_d = 15'd0;
        end

        if (act_b_q && en_b_q) begin
            r_d = rep4(vga.rd_data[2]);
            g_d = rep4(vga.rd_data[1]);
            b_d = rep4(vga.rd_data[0]);
        end else begin
            r_d = 4'h0;
            g_d = 4'h0;
            b_d = 4'h0;
        end
    end

    // All pipeline state; sync stages idle high, everything else low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q     <= 1'b0;
            hcnt_q    <= 10'd0;
            vcnt_q    <= 10'd0;
            frame_q   <= 1'b0;
            rd_addr_q <= 15'd0;
            hs_a_q    <= 1'b1;
            vs_a_q    <= 1'b1;
            act_a_q   <= 1'b0;
            en_a_q    <= 1'b0;
            hs_b_q    <= 1'b1;
            vs_b_q    <= 1'b1;
            act_b_q   <= 1'b0;
            en_b_q    <= 1'b0;
            r_q       <= 4'h0;
            g_q       <= 4'h0;
            b_q       <= 4'h0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_q   <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            frame_q   <= frame_d;
            rd_addr_q <= rd_addr_d;
            hs_a_q    <= hs_a_d;
            vs_a_q    <= vs_a_d;
            act_a_q   <= act_a_d;
            en_a_q    <= en_a_d;
            hs_b_q    <= hs_a_q;
            vs_b_q    <= vs_a_q;
            act_b_q   <= act_a_q;
            en_b_q    <= en_a_q;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_b_q;
            vs_q      <= vs_b_q;
            blank_q   <= act_b_q;
        end
    end

    assign vga.rd_addr   = rd_addr_q;
    assign vga.VGA_R     = r_q;
    assign vga.VGA_G     = g_q;
    assign vga.VGA_B     = b_q;
    assign vga.VGA_HS    = hs_q;
    assign vga.VGA_VS    = vs_q;
    assign vga.VGA_BLANK = blank_q;
    assign vga.VGA_SYNC  = 1'b0;
    assign vga.frame     = frame_q;

endmodule

// File: tb/tb_lector_vga.sv
// Testbench for lector_vga. Horizontal timing uses the default 640/16/96/48;
// the vertical total is shortened to 18 lines so two whole frames fit in a
// short run. A RAM model returns addr[2:0] (or 3'b111 when forced).
module tb_lector_vga;
    localparam int H_ACT = 640, H_FP = 16, H_SYN = 96, H_BP = 48;
    localparam int V_ACT = 12,  V_FP = 2,  V_SYN = 2,  V_BP = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
    localparam int FRAME = H_TOT * V_TOT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic [11:0] rgb;
    } pins_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #10 clk = ~clk;

    lector_vga_if vif();

    lector_vga #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYN(H_SYN), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYN(V_SYN), .V_BP(V_BP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vga  (vif)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_print = 0;
    logic  ram_force = 1'b0;
    bit    mon_en = 1'b0;
    bit    mon_first = 1'b0;
    bit    have_prev = 1'b0;
    int    mh = 0;
    int    mv = 0;
    logic [14:0] prev_addr = 15'd0;
    pins_t exp_q[$];
    pins_t mon_got;
    pins_t mon_want;

    function automatic logic [14:0] exp_addr(int h, int v);
        if (h < H_ACT && v < V_ACT) return 15'((v / 4) * 160 + (h / 4));
        return 15'd0;
    endfunction

    function automatic pins_t exp_pins(int h, int v, logic en, logic frc);
        pins_t       p;
        logic [14:0] a;
        logic [2:0]  d;
        logic        act;
        act = (h < H_ACT) && (v < V_ACT);
        a = exp_addr(h, v);
        d = frc ? 3'b111 : a[2:0];
        p.hs = !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYN);
        p.vs = !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYN);
        p.blank = act;
        p.rgb = (act && en) ? {{4{d[2]}}, {4{d[1]}}, {4{d[0]}}} : 12'h000;
        return p;
    endfunction

    // Framebuffer RAM model: one clock of read latency.
    always @(posedge clk) vif.rd_data <= ram_force ? 3'b111 : vif.rd_addr[2:0];

    // Scoreboard: expected pins are queued per counter cycle and popped when
    // the pipeline delivers them; frame and rd_addr are checked each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mon_first) begin
                mh = 0; mv = 0; mon_first = 1'b0;
            end else if (mh == H_TOT - 1) begin
                mh = 0;
                mv = (mv == V_TOT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            n_cmp++;
            if (vif.frame !== ((mh == 0) && (mv == 0))) begin
                n_bad++;
                if (n_print < 20) $display("FAIL sb_frame h=%0d v=%0d got %b want %b", mh, mv, vif.frame, (mh == 0) && (mv == 0));
                n_print++;
            end
            if (have_prev) begin
                n_cmp++;
                if (vif.rd_addr !== prev_addr) begin
                    n_bad++;
                    if (n_print < 20) $display("FAIL sb_rd_addr h=%0d v=%0d got %0d want %0d", mh, mv, vif.rd_addr, prev_addr);
                    n_print++;
                end
            end
            prev_addr = exp_addr(mh, mv);
            have_prev = 1'b1;
            exp_q.push_back(exp_pins(mh, mv, vif.vgae, ram_force));
            mon_want = exp_q.pop_front();
            mon_got = {vif.VGA_HS, vif.VGA_VS, vif.VGA_BLANK, vif.VGA_R, vif.VGA_G, vif.VGA_B};
            n_cmp++;
            if (mon_got !== mon_want) begin
                n_bad++;
                if (n_print < 20) $display("FAIL sb_pins h=%0d v=%0d got %h want %h", mh, mv, mon_got, mon_want);
                n_print++;
            end
        end
    end

    task automatic start_mon();
        exp_q.delete();
        repeat (3) exp_q.push_back(pins_t'({1'b1, 1'b1, 1'b0, 12'h000}));
        mon_first = 1'b1;
        have_prev = 1'b0;
        mon_en = 1'b1;
    endtask

    // Release lands between edges; the next rising edge loads (0,0).
    task automatic do_reset();
        mon_en = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        start_mon();
    endtask

    task automatic wait_pos(input int h, input int v, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk); #1;
            if (mh == h && mv == v) found = 1'b1;
        end
        if (!found) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_pos timeout got h=%0d v=%0d want h=%0d v=%0d", mh, mv, h, v);
        end
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        reset = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (vif.VGA_HS !== 1'b1) begin n_bad++; $display("FAIL rst_hs got %b want 1", vif.VGA_HS); end
        n_cmp++; if (vif.VGA_VS !== 1'b1) begin n_bad++; $display("FAIL rst_vs got %b want 1", vif.VGA_VS); end
        n_cmp++; if (vif.VGA_BLANK !== 1'b0) begin n_bad++; $display("FAIL rst_blank got %b want 0", vif.VGA_BLANK); end
        n_cmp++; if ({vif.VGA_R, vif.VGA_G, vif.VGA_B} !== 12'h000) begin n_bad++; $display("FAIL rst_rgb got %h want 000", {vif.VGA_R, vif.VGA_G, vif.VGA_B}); end
        n_cmp++; if (vif.frame !== 1'b0) begin n_bad++; $display("FAIL rst_frame got %b want 0", vif.frame); end
        n_cmp++; if (vif.rd_addr !== 15'd0) begin n_bad++; $display("FAIL rst_rd_addr got %0d want 0", vif.rd_addr); end
        n_cmp++; if (vif.VGA_SYNC !== 1'b0) begin n_bad++; $display("FAIL rst_sync got %b want 0", vif.VGA_SYNC); end
    endtask

    // Edge e is the e-th rising edge after release; edge 1 loads (0,0), so
    // counter position h reaches the pins after edge h+4.
    task automatic test_hsync_line();
        int fall1, fall2, lows;
        logic prev;
        fall1 = -1; fall2 = -1; lows = 0; prev = 1'b1;
        do_reset();
        for (int e = 1; e <= 1700; e++) begin
            @(negedge clk); #1;
            if (vif.VGA_HS === 1'b0 && prev === 1'b1) begin
                if (fall1 < 0) fall1 = e;
                else if (fall2 < 0) fall2 = e;
            end
            if (vif.VGA_HS === 1'b0 && fall2 < 0) lows++;
            prev = vif.VGA_HS;
        end
        n_cmp++; if (fall1 != H_ACT + H_FP + 4) begin n_bad++; $display("FAIL hs_fall_edge got %0d want %0d", fall1, H_ACT + H_FP + 4); end
        n_cmp++; if (lows != H_SYN) begin n_bad++; $display("FAIL hs_low_width got %0d want %0d", lows, H_SYN); end
        n_cmp++; if (fall2 - fall1 != H_TOT) begin n_bad++; $display("FAIL hs_period got %0d want %0d", fall2 - fall1, H_TOT); end
    endtask

    // Pins after edge e show linear position e-4 of the frame.
    task automatic test_frame();
        int fr[3];
        int nfr, vs_low, blank_hi, blank_l0, blank_off;
        nfr = 0; vs_low = 0; blank_hi = 0; blank_l0 = 0; blank_off = 0;
        do_reset();
        for (int e = 1; e <= 2 * FRAME + 4; e++) begin
            @(negedge clk); #1;
            if (vif.frame === 1'b1) begin
                if (nfr < 3) fr[nfr] = e;
                nfr++;
            end
            if (e >= 4 && e <= FRAME + 3) begin
                if (vif.VGA_VS === 1'b0) vs_low++;
                if (vif.VGA_BLANK === 1'b1) blank_hi++;
                if (vif.VGA_BLANK === 1'b1 && e <= H_TOT + 3) blank_l0++;
                if (vif.VGA_BLANK === 1'b1 && e >= V_ACT * H_TOT + 4) blank_off++;
            end
        end
        n_cmp++; if (nfr != 3) begin n_bad++; $display("FAIL frame_count got %0d want 3", nfr); end
        if (nfr == 3) begin
            n_cmp++; if (fr[0] != 1) begin n_bad++; $display("FAIL frame_first got %0d want 1", fr[0]); end
            n_cmp++; if (fr[1] - fr[0] != FRAME) begin n_bad++; $display("FAIL frame_spacing1 got %0d want %0d", fr[1] - fr[0], FRAME); end
            n_cmp++; if (fr[2] - fr[1] != FRAME) begin n_bad++; $display("FAIL frame_spacing2 got %0d want %0d", fr[2] - fr[1], FRAME); end
        end
        n_cmp++; if (vs_low != V_SYN * H_TOT) begin n_bad++; $display("FAIL vs_low got %0d want %0d", vs_low, V_SYN * H_TOT); end
        n_cmp++; if (blank_hi != H_ACT * V_ACT) begin n_bad++; $display("FAIL blank_total got %0d want %0d", blank_hi, H_ACT * V_ACT); end
        n_cmp++; if (blank_l0 != H_ACT) begin n_bad++; $display("FAIL blank_line0 got %0d want %0d", blank_l0, H_ACT); end
        n_cmp++; if (blank_off != 0) begin n_bad++; $display("FAIL blank_vblank got %0d want 0", blank_off); end
    endtask

    task automatic test_addr();
        logic [11:0] px[8];
        ram_force = 1'b0;
        do_reset();
        wait_pos(0, 0, 10);
        @(negedge clk); #1;
        n_cmp++; if (vif.rd_addr !== 15'd0) begin n_bad++; $display("FAIL addr_0_0 got %0d want 0", vif.rd_addr); end
        wait_pos(H_ACT - 1, 0, 2000);
        @(negedge clk); #1;
        n_cmp++; if (vif.rd_addr !== 15'd159) begin n_bad++; $display("FAIL addr_639_0 got %0d want 159", vif.rd_addr); end
        n_cmp++; if (mh != H_ACT) begin n_bad++; $display("FAIL addr_pos got %0d want %0d", mh, H_ACT); end
        @(negedge clk); #1;
        n_cmp++; if (vif.rd_addr !== 15'd0) begin n_bad++; $display("FAIL addr_640_0 got %0d want 0", vif.rd_addr); end
        wait_pos(4, 8, 10000);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); #1;
            if (i == 1) begin
                n_cmp++; if (vif.rd_addr !== 15'd321) begin n_bad++; $display("FAIL addr_4_8 got %0d want 321", vif.rd_addr); end
            end
            px[i] = {vif.VGA_R, vif.VGA_G, vif.VGA_B};
        end
        n_cmp++; if (px[3] !== 12'h00F) begin n_bad++; $display("FAIL pix_4_8 got %h want 00f", px[3]); end
        n_cmp++; if (px[6] !== 12'h00F) begin n_bad++; $display("FAIL pix_7_8 got %h want 00f", px[6]); end
        n_cmp++; if (px[7] !== 12'h0F0) begin n_bad++; $display("FAIL pix_8_8 got %h want 0f0", px[7]); end
        wait_pos(H_ACT - 1, V_ACT - 1, 5000);
        @(negedge clk); #1;
        n_cmp++; if (vif.rd_addr !== 15'(((V_ACT - 1) / 4) * 160 + 159)) begin n_bad++; $display("FAIL addr_corner got %0d want %0d", vif.rd_addr, ((V_ACT - 1) / 4) * 160 + 159); end
        @(negedge clk); #1;
        n_cmp++; if (vif.rd_addr !== 15'd0) begin n_bad++; $display("FAIL addr_corner_off got %0d want 0", vif.rd_addr); end
    endtask

    task automatic test_vgae();
        int zeros, first_zero, ones, hs_bad, vs_bad, bl_bad;
        zeros = 0; first_zero = -1; ones = 0; hs_bad = 0; vs_bad = 0; bl_bad = 0;
        ram_force = 1'b1;
        do_reset();
        wait_pos(100, 2, 3000);
        @(posedge clk); #1 vif.vgae = 1'b0;
        for (int j = 0; j <= 160; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
                if (j == 100) vif.vgae = 1'b1;
            end
            @(negedge clk); #1;
            if ({vif.VGA_R, vif.VGA_G, vif.VGA_B} === 12'h000) begin
                if (first_zero < 0) first_zero = j;
                zeros++;
            end
            if ({vif.VGA_R, vif.VGA_G, vif.VGA_B} === 12'hFFF) ones++;
            if (vif.VGA_HS !== 1'b1) hs_bad++;
            if (vif.VGA_VS !== 1'b1) vs_bad++;
            if (vif.VGA_BLANK !== 1'b1) bl_bad++;
        end
        n_cmp++; if (first_zero != 3) begin n_bad++; $display("FAIL vgae_delay got %0d want 3", first_zero); end
        n_cmp++; if (zeros != 100) begin n_bad++; $display("FAIL vgae_black_len got %0d want 100", zeros); end
        n_cmp++; if (ones != 61) begin n_bad++; $display("FAIL vgae_white_len got %0d want 61", ones); end
        n_cmp++; if (hs_bad + vs_bad + bl_bad != 0) begin n_bad++; $display("FAIL vgae_sync_glitch got hs=%0d vs=%0d blank=%0d want 0", hs_bad, vs_bad, bl_bad); end
        ram_force = 1'b0;
    endtask

    task automatic test_reset_midframe();
        ram_force = 1'b0;
        do_reset();
        wait_pos(299, 5, 6000);
        @(posedge clk); #3;
        n_cmp++; if (vif.VGA_BLANK !== 1'b1) begin n_bad++; $display("FAIL mid_pre_blank got %b want 1", vif.VGA_BLANK); end
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++; if (vif.VGA_HS !== 1'b1 || vif.VGA_VS !== 1'b1) begin n_bad++; $display("FAIL mid_sync got %b%b want 11", vif.VGA_HS, vif.VGA_VS); end
        n_cmp++; if (vif.VGA_BLANK !== 1'b0) begin n_bad++; $display("FAIL mid_blank got %b want 0", vif.VGA_BLANK); end
        n_cmp++; if ({vif.VGA_R, vif.VGA_G, vif.VGA_B} !== 12'h000) begin n_bad++; $display("FAIL mid_rgb got %h want 000", {vif.VGA_R, vif.VGA_G, vif.VGA_B}); end
        n_cmp++; if (vif.rd_addr !== 15'd0 || vif.frame !== 1'b0) begin n_bad++; $display("FAIL mid_addr_frame got %0d/%b want 0/0", vif.rd_addr, vif.frame); end
        #9 reset = 1'b1;
        start_mon();
        @(negedge clk); #1;
        n_cmp++; if (vif.frame !== 1'b1) begin n_bad++; $display("FAIL mid_restart_frame got %b want 1", vif.frame); end
        @(negedge clk); #1;
        n_cmp++; if (vif.frame !== 1'b0) begin n_bad++; $display("FAIL mid_frame_width got %b want 0", vif.frame); end
        repeat (900) @(negedge clk);
    endtask

    initial begin
        vif.vgae = 1'b1;
        test_reset();
        test_hsync_line();
        test_frame();
        test_addr();
        test_vgae();
        test_reset_midframe();
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lector_vga.md
LECTOR_VGA -- requirements
Module: lector_vga

Interface
REQ-001 The block SHALL run on one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameters, one per line (name, default, meaning):
- H_ACT 640: visible pixels per line.
- H_FP 16: horizontal front porch.
- H_SYN 96: horizontal sync width.
- H_BP 48: horizontal back porch.
- V_ACT 480: visible lines.
- V_FP 10: vertical front porch.
- V_SYN 2: vertical sync width.
- V_BP 33: vertical back porch.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: pixel clock; all state is on the rising edge.
- reset, in, 1: asynchronous, active-low.
- vgae, in, 1: video enable; when 0, RGB is forced to black.
- rd_addr, out, 15: framebuffer read address.
- rd_data, in, 3: framebuffer pixel {R,G,B}; synchronous RAM, 1-clock read latency.
- VGA_R, out, 4: red.
- VGA_G, out, 4: green.
- VGA_B, out, 4: blue.
- VGA_HS, out, 1: horizontal sync, active-low.
- VGA_VS, out, 1: vertical sync, active-low.
- VGA_BLANK, out, 1: active-low blank (1 = visible).
- VGA_SYNC, out, 1: composite sync, constant 0.
- frame, out, 1: one-clock frame-start pulse.

Function
REQ-004 hcnt SHALL count 0..H_TOT-1 (H_TOT = 800) and wrap to 0; on wrap, vcnt SHALL increment over 0..V_TOT-1 (V_TOT = 525) and wrap to 0.
REQ-005 The active region SHALL be hcnt<H_ACT and vcnt<V_ACT.
REQ-006 HS SHALL be low for hcnt in 656..751; VS SHALL be low for vcnt in 490..491; both values are derived from the parameters.
REQ-007 Framebuffer geometry SHALL be 160x120, with each framebuffer pixel covering 4x4 screen pixels: fx = hcnt[9:2], fy = vcnt[9:2].
REQ-008 rd_addr SHALL be registered as fy*160+fx, computed as (fy<<7)+(fy<<5)+fx with no multiplier, and SHALL be 0 outside the active region.
REQ-009 The pipeline SHALL be: stage 1 counters; stage 2 rd_addr register; stage 3 rd_data valid; stage 4 output registers.
- The pins SHALL reflect counter position (h,v) exactly 3 clocks after the counters hold (h,v).
REQ-010 HS, VS, the active flag and vgae SHALL travel through a 3-deep delay line so they stay aligned with RGB.
REQ-011 Color mapping: each rd_data bit SHALL be replicated to 4 bits (1 -> 4'hF, 0 -> 4'h0); R = bit2, G = bit1, B = bit0.
REQ-012 RGB SHALL be 0 whenever the delayed active flag is 0 or the delayed vgae is 0.
REQ-013 VGA_BLANK SHALL equal the delayed active flag and SHALL be independent of vgae.
REQ-014 frame SHALL be high for exactly one clock, in the cycle where the counters hold (0,0). It is not pipeline-delayed.
REQ-015 vgae toggling mid-line SHALL take effect at the pins exactly 3 clocks later, with no glitch on HS, VS or BLANK.
REQ-016 rd_data SHALL be treated as don't-care outside the active region.

Reset
REQ-017 While reset=0:
- hcnt and vcnt SHALL be 0.
- All delay-line registers SHALL be 0, except the HS/VS delay stages, which SHALL be 1.
- rd_addr SHALL be 0.
- RGB SHALL be 0, VGA_HS SHALL be 1, VGA_VS SHALL be 1, VGA_BLANK SHALL be 0, frame SHALL be 0.
REQ-018 Reset asserted mid-frame SHALL clear all state immediately, without waiting for a clock edge.
REQ-019 On the first rising edge after reset release, counting SHALL start from (0,0), with frame=1 during that first counter cycle.
- The first visible pixel SHALL appear at the pins 3 clocks after release.

Verification
REQ-020 Reset, then a free run for one line: VGA_HS low for exactly 96 clocks, with its falling edge 656+3 clocks after release; the line period is 800 clocks.
REQ-021 Free run over two frames: frame pulses are 420000 clocks apart; VGA_VS is low for 1600 clocks (2 lines); VGA_BLANK is high for 640 clocks per line on lines 0..479 only.
REQ-022 RAM model with data = addr[2:0]:
- At h=4, v=8 the bench sees rd_addr = 2*160+1 = 321.
- The corresponding pins 3 clocks later show R=4'h0, G=4'h0, B=4'hF (321 mod 8 = 1).
- Pixel values change every 4 clocks across the line.
REQ-023 Corner addresses: rd_addr = 0 at (0,0); 159 at h=639, v=0; 19199 at h=639, v=479; 0 at h=640.
REQ-024 With rd_data forced to 3'b111, drive vgae=0 for 100 clocks mid-line: RGB is 0 for exactly 100 clocks, starting 3 clocks after the vgae fall, while HS, VS and BLANK are unchanged.
REQ-025 Assert reset at h=300, v=200 for 10 ns, between clock edges:
- The outputs go to their reset values immediately.
- After release, the counters restart at (0,0) and frame=1 in the first counter cycle.
